// File: rtl/decimal_point_sequencer_pkg.sv
// Shared definitions for the decimal point sequencer: mode encodings and default digit indices.
package decimal_point_sequencer_pkg;

    typedef enum logic [1:0] {
        DP_RUN  = 2'd0,
        DP_SET  = 2'd1,
        DP_RING = 2'd2
    } dp_state_t;

    localparam int DEF_N_DIGITS  = 6;
    localparam int DEF_COLON_LSB = 3;
    localparam int DEF_SEC_DP    = 1;
    localparam int DEF_ALARM_DP  = 0;
    localparam int DEF_PM_DP     = 5;
    localparam int DEF_BLINK_DIV = 8;

endpackage

// File: rtl/decimal_point_sequencer_blink_timer.sv
// Blink divider: counts fast strobes and toggles the blink phase every DIV strobes.
module dp_blink_timer #(
    parameter int DIV = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_stb,
    output logic o_phase
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          ph;
    logic          ph_nxt;

    // A clear (mode change) beats a coincident strobe so each new mode starts on a full lit half.
    always_comb begin
        cnt_nxt = cnt;
        ph_nxt  = ph;
        if (i_clr) begin
            cnt_nxt = '0;
            ph_nxt  = 1'b1;
        end else if (i_stb) begin
            if (cnt == LAST) begin
                cnt_nxt = '0;
                ph_nxt  = ~ph;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
            ph  <= 1'b1;
        end else begin
            cnt <= cnt_nxt;
            ph  <= ph_nxt;
        end
    end

    // Phase in effect after this edge, so the caller's output register has no extra lag.
    assign o_phase = ph_nxt;

endmodule

// File: rtl/decimal_point_sequencer.sv
// Decimal point / colon driver with RUN/SET/RING mode FSM, colon phase and blink timer.
// Optional build macro AMPM_INDICATOR_EN enables the PM indicator DP.
module decimal_point_sequencer
    import decimal_point_sequencer_pkg::*;
#(
    parameter int N_DIGITS  = DEF_N_DIGITS,
    parameter int COLON_LSB = DEF_COLON_LSB,
    parameter int SEC_DP    = DEF_SEC_DP,
    parameter int ALARM_DP  = DEF_ALARM_DP,
    parameter int PM_DP     = DEF_PM_DP,
    parameter int BLINK_DIV = DEF_BLINK_DIV
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_sec_stb,
    input  logic                i_blink_stb,
    input  logic                i_set_time,
    input  logic                i_alarm_ring,
    input  logic                i_alarm_en,
    input  logic                i_pm,
    output logic [N_DIGITS-1:0] o_dp,
    output logic [1:0]          o_mode
);

    localparam bit BASE_CLASH =
        (SEC_DP == COLON_LSB) || (SEC_DP == COLON_LSB + 1) ||
        (ALARM_DP == COLON_LSB) || (ALARM_DP == COLON_LSB + 1) ||
        (SEC_DP == ALARM_DP) || (COLON_LSB + 1 >= N_DIGITS) ||
        (SEC_DP >= N_DIGITS) || (ALARM_DP >= N_DIGITS) || (BLINK_DIV < 2);
    localparam bit PM_CLASH =
        (PM_DP == COLON_LSB) || (PM_DP == COLON_LSB + 1) ||
        (PM_DP == SEC_DP) || (PM_DP == ALARM_DP) || (PM_DP >= N_DIGITS);

    generate
        if (BASE_CLASH || PM_CLASH) begin : g_idx_clash
            $error("decimal_point_sequencer: DP index parameters collide or are out of range");
        end
    endgenerate

    dp_state_t             state;
    dp_state_t             next_state;
    logic                  state_change;
    logic                  colon_ph;
    logic                  colon_nxt;
    logic                  post_reset;
    logic                  blink_nxt;
    logic [N_DIGITS-1:0]   dp_nxt;

    always_comb begin
        next_state = DP_RUN;
        if (i_alarm_ring) begin
            next_state = DP_RING;
        end else if (i_set_time) begin
            next_state = DP_SET;
        end
    end

    assign state_change = (next_state != state);

    dp_blink_timer #(
        .DIV (BLINK_DIV)
    ) u_blink (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (state_change),
        .i_stb   (i_blink_stb),
        .o_phase (blink_nxt)
    );

    // Leaving reset counts as entering RUN, so the colon is lit on the first output.
    always_comb begin
        colon_nxt = colon_ph;
        if (next_state == DP_RUN) begin
            if (state != DP_RUN || post_reset) begin
                colon_nxt = 1'b1;
            end else if (i_sec_stb) begin
                colon_nxt = ~colon_ph;
            end
        end
    end

    always_comb begin
        dp_nxt = '0;
        case (next_state)
            DP_RUN: begin
                dp_nxt[COLON_LSB +: 2] = {2{colon_nxt}};
                dp_nxt[SEC_DP]         = 1'b1;
                dp_nxt[ALARM_DP]       = i_alarm_en;
`ifdef AMPM_INDICATOR_EN
                dp_nxt[PM_DP]          = i_pm;
`endif
            end
            DP_SET: begin
                dp_nxt[COLON_LSB +: 2] = 2'b11;
                dp_nxt[SEC_DP]         = blink_nxt;
                dp_nxt[ALARM_DP]       = i_alarm_en;
`ifdef AMPM_INDICATOR_EN
                dp_nxt[PM_DP]          = i_pm;
`endif
            end
            DP_RING: dp_nxt = {N_DIGITS{blink_nxt}};
            default: dp_nxt = '0;
        endcase
    end

`ifndef AMPM_INDICATOR_EN
    logic unused_pm;
    assign unused_pm = i_pm;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= DP_RUN;
            colon_ph   <= 1'b0;
            post_reset <= 1'b1;
            o_dp       <= '0;
        end else begin
            state      <= next_state;
            colon_ph   <= colon_nxt;
            post_reset <= 1'b0;
            o_dp       <= dp_nxt;
        end
    end

    assign o_mode = state;

endmodule

// File: tb/tb_decimal_point_sequencer.sv
// Self-checking bench for decimal_point_sequencer; expected outputs queued as stimulus is driven.
module tb_decimal_point_sequencer;

    typedef struct packed {
        logic [5:0] dp;
        logic [1:0] mode;
    } exp_t;

    localparam logic [5:0] RUN_ON  = 6'b011010;
    localparam logic [5:0] RUN_OFF = 6'b000010;
    localparam logic [5:0] SET_ON  = 6'b011010;
    localparam logic [5:0] SET_OFF = 6'b011000;
    localparam logic [5:0] ALL_ON  = 6'b111111;
`ifdef AMPM_INDICATOR_EN
    localparam logic [5:0] PM_BIT  = 6'b100000;
`else
    localparam logic [5:0] PM_BIT  = 6'b000000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_stb = 1'b0;
    logic       blink_stb = 1'b0;
    logic       set_time = 1'b0;
    logic       alarm_ring = 1'b0;
    logic       alarm_en = 1'b0;
    logic       pm = 1'b0;
    logic [5:0] dp;
    logic [1:0] mode;

    exp_t exp_q[$];
    exp_t exp_v;
    int   checks = 0;
    int   errors = 0;

    decimal_point_sequencer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sec_stb    (sec_stb),
        .i_blink_stb  (blink_stb),
        .i_set_time   (set_time),
        .i_alarm_ring (alarm_ring),
        .i_alarm_en   (alarm_en),
        .i_pm         (pm),
        .o_dp         (dp),
        .o_mode       (mode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (dp !== 6'b0) begin errors++; $display("[TB] FAIL reset_dp got %b want %b", dp, 6'b0); end
        checks++;
        if (mode !== 2'd0) begin errors++; $display("[TB] FAIL reset_mode got %0d want 0", mode); end
        rst = 1'b0;
        exp_q.push_back('{RUN_ON, 2'd0});
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (dp !== exp_v.dp) begin errors++; $display("[TB] FAIL release_dp got %b want %b", dp, exp_v.dp); end
        set_time = 1'b1;
        tick();
        blink_stb = 1'b1;
        tick();
        blink_stb = 1'b0;
        set_time = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dp !== 6'b0) begin errors++; $display("[TB] FAIL async_reset_dp got %b want %b", dp, 6'b0); end
        checks++;
        if (mode !== 2'd0) begin errors++; $display("[TB] FAIL async_reset_mode got %0d want 0", mode); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('{RUN_ON, 2'd0});
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (dp !== exp_v.dp || mode !== exp_v.mode) begin
            errors++;
            $display("[TB] FAIL rerelease got dp=%b mode=%0d want dp=%b mode=%0d", dp, mode, exp_v.dp, exp_v.mode);
        end
    endtask

    task automatic test_run();
        logic [3:0] pulses;
        logic       col;
        pulses = 4'b1101;
        col = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sec_stb = pulses[i];
            if (pulses[i]) col = ~col;
            exp_q.push_back('{col ? RUN_ON : RUN_OFF, 2'd0});
            tick();
            sec_stb = 1'b0;
            exp_v = exp_q.pop_front();
            checks++;
            if (dp !== exp_v.dp || mode !== exp_v.mode) begin
                errors++;
                $display("[TB] FAIL run_colon step %0d got dp=%b mode=%0d want dp=%b mode=%0d", i, dp, mode, exp_v.dp, exp_v.mode);
            end
        end
    endtask

    task automatic test_set();
        set_time = 1'b1;
        exp_q.push_back('{SET_ON, 2'd1});
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (dp !== exp_v.dp || mode !== exp_v.mode) begin
            errors++;
            $display("[TB] FAIL set_entry got dp=%b mode=%0d want dp=%b mode=%0d", dp, mode, exp_v.dp, exp_v.mode);
        end
        for (int i = 1; i <= 16; i++) begin
            blink_stb = 1'b1;
            sec_stb = (i % 3 == 0);
            exp_q.push_back('{(i < 8 || i == 16) ? SET_ON : SET_OFF, 2'd1});
            tick();
            blink_stb = 1'b0;
            sec_stb = 1'b0;
            exp_v = exp_q.pop_front();
            checks++;
            if (dp !== exp_v.dp || mode !== exp_v.mode) begin
                errors++;
                $display("[TB] FAIL set_blink strobe %0d got dp=%b mode=%0d want dp=%b mode=%0d", i, dp, mode, exp_v.dp, exp_v.mode);
            end
        end
    endtask

    task automatic test_ring();
        alarm_ring = 1'b1;
        exp_q.push_back('{ALL_ON, 2'd2});
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (dp !== exp_v.dp || mode !== exp_v.mode) begin
            errors++;
            $display("[TB] FAIL ring_entry got dp=%b mode=%0d want dp=%b mode=%0d", dp, mode, exp_v.dp, exp_v.mode);
        end
        for (int i = 1; i <= 8; i++) begin
            blink_stb = 1'b1;
            sec_stb = (i == 4);
            exp_q.push_back('{(i < 8) ? ALL_ON : 6'b000000, 2'd2});
            tick();
            blink_stb = 1'b0;
            sec_stb = 1'b0;
            exp_v = exp_q.pop_front();
            checks++;
            if (dp !== exp_v.dp || mode !== exp_v.mode) begin
                errors++;
                $display("[TB] FAIL ring_blink strobe %0d got dp=%b mode=%0d want dp=%b mode=%0d", i, dp, mode, exp_v.dp, exp_v.mode);
            end
        end
        alarm_ring = 1'b0;
        exp_q.push_back('{SET_ON, 2'd1});
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (dp !== exp_v.dp || mode !== exp_v.mode) begin
            errors++;
            $display("[TB] FAIL ring_to_set got dp=%b mode=%0d want dp=%b mode=%0d", dp, mode, exp_v.dp, exp_v.mode);
        end
    endtask

    task automatic test_alarm_pm();
        logic [1:0] set_seq [4];
        logic [1:0] ring_seq [4];
        logic [5:0] want [4];
        logic [1:0] want_mode [4];
        set_seq  = '{2'd0, 2'd1, 2'd1, 2'd0};
        ring_seq = '{2'd0, 2'd0, 2'd1, 2'd0};
        want     = '{RUN_ON | 6'b1 | PM_BIT, SET_ON | 6'b1 | PM_BIT, ALL_ON, RUN_ON | 6'b1 | PM_BIT};
        want_mode = '{2'd0, 2'd1, 2'd2, 2'd0};
        alarm_en = 1'b1;
        pm = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_time = set_seq[i][0];
            alarm_ring = ring_seq[i][0];
            exp_q.push_back('{want[i], want_mode[i]});
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (dp !== exp_v.dp || mode !== exp_v.mode) begin
                errors++;
                $display("[TB] FAIL alarm_pm step %0d got dp=%b mode=%0d want dp=%b mode=%0d", i, dp, mode, exp_v.dp, exp_v.mode);
            end
        end
        alarm_en = 1'b0;
        pm = 1'b0;
        exp_q.push_back('{RUN_ON, 2'd0});
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (dp !== exp_v.dp) begin errors++; $display("[TB] FAIL alarm_pm_clear got %b want %b", dp, exp_v.dp); end
    endtask

    task automatic test_collision();
        set_time = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            blink_stb = 1'b1;
            tick();
        end
        blink_stb = 1'b1;
        sec_stb = 1'b1;
        set_time = 1'b0;
        exp_q.push_back('{RUN_ON, 2'd0});
        tick();
        blink_stb = 1'b0;
        sec_stb = 1'b0;
        exp_v = exp_q.pop_front();
        checks++;
        if (dp !== exp_v.dp || mode !== exp_v.mode) begin
            errors++;
            $display("[TB] FAIL collision_out got dp=%b mode=%0d want dp=%b mode=%0d", dp, mode, exp_v.dp, exp_v.mode);
        end
        checks++;
        if (dut.u_blink.cnt !== '0) begin errors++; $display("[TB] FAIL collision_cnt got %0d want 0", dut.u_blink.cnt); end
        checks++;
        if (dut.u_blink.ph !== 1'b1) begin errors++; $display("[TB] FAIL collision_blink_ph got %b want 1", dut.u_blink.ph); end
        checks++;
        if (dut.colon_ph !== 1'b1) begin errors++; $display("[TB] FAIL collision_colon_ph got %b want 1", dut.colon_ph); end
    endtask

    task automatic test_back_to_back();
        sec_stb = 1'b1;
        tick();
        sec_stb = 1'b0;
        alarm_ring = 1'b1;
        exp_q.push_back('{ALL_ON, 2'd2});
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (dp !== exp_v.dp || mode !== exp_v.mode) begin
            errors++;
            $display("[TB] FAIL b2b_ring got dp=%b mode=%0d want dp=%b mode=%0d", dp, mode, exp_v.dp, exp_v.mode);
        end
        alarm_ring = 1'b0;
        sec_stb = 1'b1;
        exp_q.push_back('{RUN_ON, 2'd0});
        tick();
        sec_stb = 1'b0;
        exp_v = exp_q.pop_front();
        checks++;
        if (dp !== exp_v.dp || mode !== exp_v.mode) begin
            errors++;
            $display("[TB] FAIL b2b_run_entry got dp=%b mode=%0d want dp=%b mode=%0d", dp, mode, exp_v.dp, exp_v.mode);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_set();
        test_ring();
        test_alarm_pm();
        test_collision();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
